uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Transmit end of the core's UART peripheral path: consumes the one-cycle byte-write pulses the data memory stage issues on stores to 0x1000_0000 and serialises them onto a TX line.
- Format: 8N1, LSB first.
- A small FIFO absorbs bursts of back-to-back stores so the core never stalls.
- Sits at top level between data_memory (uart_dout/uart_we) and the board TX pin.

Parameters:
- CLK_DIV, 868, clock cycles per bit (100 MHz / 115200); legal range >= 2.
- FIFO_AW, 4, log2 of FIFO depth (default 16 entries); legal range >= 1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- din  input  32  write data from data memory; only din[7:0] is transmitted
- we  input  1  one-cycle write strobe; pushes din[7:0] into the FIFO
- txd  output  1  serial line, idle high
- busy  output  1  high while a frame is in flight or the FIFO is non-empty
- fifo_full  output  1  FIFO holds 2^FIFO_AW entries
- overflow  output  1  sticky; set when a write is dropped, cleared only by reset

Behaviour:
- Reset (async assert, sync release):
  - txd=1, busy=0, fifo_full=0, overflow=0.
  - FIFO empty, FSM in IDLE, counters 0.
  - Asserting reset mid-frame forces txd=1 immediately; the partially sent byte and all FIFO contents are lost.
- FIFO push and drop rules:
  - A write with we=1 sampled at edge E0 stores din[7:0] at E0.
  - When the FIFO is full and no pop occurs on the same edge, the write is dropped and overflow is set at that edge.
  - A push and a pop on the same edge while full are both accepted; occupancy is unchanged and overflow is not set.
  - A push and a pop on the same edge while empty are not possible: the pop needs non-empty state registered on the previous edge.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If the FIFO is non-empty, pop at the next edge, load the shift register, reset the bit counter and baud counter, go to START (txd=0 from that edge).
  - START: hold txd=0 for CLK_DIV cycles, then go to DATA.
  - DATA: txd = shift[0]. Every CLK_DIV cycles, shift right and increment the bit index. After bit 7 has been held CLK_DIV cycles, go to STOP.
  - STOP: txd=1 for CLK_DIV cycles.
    - If the FIFO is non-empty at the end of the stop bit, pop and go directly to START. No extra idle cycle is inserted between frames.
    - Otherwise go to IDLE.
- Latency: a write at E0 into an empty FIFO with the FSM in IDLE gives a falling edge on txd at E1. The frame is exactly 10*CLK_DIV cycles (E1 to E1+10*CLK_DIV).
- Baud counter: counts 0..CLK_DIV-1 and wraps. Its width is clog2(CLK_DIV). The state advances on the wrap.
- FIFO pointers: FIFO_AW+1 bits, wrap modulo 2^(FIFO_AW+1). Full when the MSBs differ and the low bits are equal; empty when the pointers are equal.
- busy is combinational: (state != IDLE) || !empty.
- din[31:8] is ignored; no parity or error checking is performed.

Decomposition:
- Package mspu_uart_pkg holds:
  - typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t
  - localparam UART_ADDR = 32'h1000_0000
  - localparam UART_DEFAULT_DIV = 868
- Sub-module sync_fifo (WIDTH=8, AW=FIFO_AW):
  - Ports: clk, reset, push, din, pop, dout, empty, full.
  - First-word-fall-through; same reset convention as uart_tx.
- uart_tx contains the FSM, baud counter, shift register and the overflow flag.

Test Plan (all with CLK_DIV=4, FIFO_AW=2):
1. Single byte: we=1, din=32'h0000_0055 at E0 -> txd=1 at E0; from E1, sampled every 4 cycles: 0,1,0,1,0,1,0,1,0,1. busy drops at E1+40.
2. Upper bits ignored: din=32'hDEAD_BE41 -> transmitted bit sequence 0,1,0,0,0,0,0,1,0,1 (0x41 LSB first plus stop).
3. Back-to-back: writes 0x31, 0x32, 0x33 on consecutive cycles -> three contiguous 40-cycle frames with no idle gap; txd=1 and busy=0 at E1+120.
4. Overflow: 6 writes 0x01..0x06 on consecutive cycles -> 0x01 popped at E1; 0x02..0x05 fill the FIFO; 0x06 dropped. overflow=1 from the 6th write edge; frames 0x01..0x05 sent, 200 cycles total.
5. Simultaneous push/pop at full: fill 4 entries during a frame, then write 0x7E on the edge the stop bit ends -> accepted, overflow stays 0, 0x7E sent last.
6. Reset mid-frame: drop reset during DATA bit 3 of 0xA5 with 2 bytes queued -> txd=1 in the same cycle; after release busy=0 and fifo_full=0, and no residual frame appears within 100 cycles.

Source files
------------

// File: rtl/mspu_uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmit path.
package mspu_uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  localparam logic [31:0] UART_ADDR        = 32'h1000_0000;
  localparam int unsigned UART_DEFAULT_DIV = 868;

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// First-word-fall-through synchronous FIFO; pointers carry one wrap bit
// to tell full from empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees the slot the push lands in.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 LSB-first UART transmitter fed by single-cycle byte writes through a
// small FIFO; back-to-back frames are sent without idle gaps.
module uart_tx
  import mspu_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = UART_DEFAULT_DIV,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] din,
  input  logic        we,
  output logic        txd,
  output logic        busy,
  output logic        fifo_full,
  output logic        overflow
);

  localparam int unsigned   BW        = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

  uart_tx_state_t state, state_nxt;
  logic [BW-1:0]  baud_cnt, baud_nxt;
  logic [2:0]     bit_idx, bit_nxt;
  logic [7:0]     shift, shift_nxt;
  logic           baud_wrap;
  logic           pop;
  logic           fifo_empty;
  logic [7:0]     fifo_dout;
  logic           unused_din;

  assign unused_din = ^din[31:8];

  sync_fifo #(
    .WIDTH (8),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (we),
    .din   (din[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign baud_wrap = (baud_cnt == BAUD_LAST);
  assign busy      = (state != IDLE) || !fifo_empty;

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_wrap ? '0 : baud_cnt + BW'(1);
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        baud_nxt = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = fifo_dout;
          bit_nxt   = '0;
          state_nxt = START;
        end
      end
      START: begin
        if (baud_wrap) state_nxt = DATA;
      end
      DATA: begin
        if (baud_wrap) begin
          shift_nxt = {1'b0, shift[7:1]};
          bit_nxt   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        // Chain straight into the next start bit when more data is queued.
        if (baud_wrap) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_nxt = fifo_dout;
            bit_nxt   = '0;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    txd = 1'b1;
    case (state)
      START:   txd = 1'b0;
      DATA:    txd = shift[0];
      default: txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      shift    <= shift_nxt;
      if (we && fifo_full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: randomized writes compared cycle by cycle against a
// queue-plus-frame-timer model of the transmitter.
module tb_uart_tx;

  localparam int unsigned DIV   = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic [31:0] din = '0;
  logic        txd, busy, fifo_full, overflow;

  int checks = 0;
  int errors = 0;

  uart_tx #(.CLK_DIV(DIV), .FIFO_AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .we        (we),
    .txd       (txd),
    .busy      (busy),
    .fifo_full (fifo_full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Model: queue of pending bytes, the frame on the wire and when it began.
  logic [7:0] q[$];
  bit         m_active;
  bit         m_ovf;
  int         m_start;
  int         cyc;
  logic [7:0] m_byte;
  logic [3:0] exp_v;  // {txd, busy, fifo_full, overflow}

  function automatic void model_reset();
    q.delete();
    m_active = 1'b0;
    m_ovf    = 1'b0;
    exp_v    = 4'b1000;
  endfunction

  function automatic void model_edge(input logic w, input logic [7:0] b);
    int sz;
    int idx;
    bit pop_now, push_ok;
    logic etxd;
    cyc++;
    sz = q.size();
    if (m_active && cyc == m_start + 10*DIV) m_active = 1'b0;
    pop_now = !m_active && sz > 0;
    push_ok = w && (sz < DEPTH || pop_now);
    if (w && !push_ok) m_ovf = 1'b1;
    if (pop_now) begin
      m_byte   = q.pop_front();
      m_active = 1'b1;
      m_start  = cyc;
    end
    if (push_ok) q.push_back(b);
    etxd = 1'b1;
    if (m_active) begin
      idx = (cyc - m_start) / DIV;
      if (idx == 0) etxd = 1'b0;
      else if (idx <= 8) etxd = m_byte[idx-1];
    end
    exp_v = {etxd, (m_active || q.size() > 0), (q.size() == DEPTH), m_ovf};
  endfunction

  task automatic tick(input logic w, input logic [31:0] d);
    we  = w;
    din = d;
    @(posedge clk);
    model_edge(w, d[7:0]);
    #1;
    we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({txd, busy, fifo_full, overflow} !== 4'b1000) begin
      errors++;
      $display("FAIL reset.outputs got=%b exp=1000", {txd, busy, fifo_full, overflow});
    end
    reset = 1'b1;
    cyc   = 0;
    model_reset();
  endtask

  task automatic test_single();
    logic [9:0] frame, got;
    frame = {1'b1, 8'h55, 1'b0};
    got   = '0;
    for (int k = 0; k < 46; k++) begin
      tick(k == 0, (k == 0) ? 32'h0000_0055 : 32'h0);
      checks++;
      if ({txd, busy, fifo_full, overflow} !== exp_v) begin
        errors++;
        $display("FAIL single.cycle cyc=%0d got=%b exp=%b", cyc, {txd, busy, fifo_full, overflow}, exp_v);
      end
      if (k >= 1 && k <= 37 && ((k - 1) % 4) == 0) got[(k-1)/4] = txd;
      if (k == 40 || k == 41) begin
        checks++;
        if (busy !== (k == 40)) begin
          errors++;
          $display("FAIL single.busy_end k=%0d got=%b exp=%b", k, busy, (k == 40));
        end
      end
    end
    checks++;
    if (got !== frame) begin
      errors++;
      $display("FAIL single.frame got=%b exp=%b", got, frame);
    end
  endtask

  task automatic test_upper_bits();
    logic [9:0]  frame, got;
    logic [31:0] rnd, d;
    frame = {1'b1, 8'h41, 1'b0};
    for (int r = 0; r < 2; r++) begin
      rnd = $urandom();
      d   = (r == 0) ? 32'hDEAD_BE41 : {rnd[31:8], 8'h41};
      got = '0;
      for (int k = 0; k < 44; k++) begin
        tick(k == 0, (k == 0) ? d : rnd);
        checks++;
        if ({txd, busy, fifo_full, overflow} !== exp_v) begin
          errors++;
          $display("FAIL upper.cycle cyc=%0d got=%b exp=%b", cyc, {txd, busy, fifo_full, overflow}, exp_v);
        end
        if (k >= 1 && k <= 37 && ((k - 1) % 4) == 0) got[(k-1)/4] = txd;
      end
      checks++;
      if (got !== frame) begin
        errors++;
        $display("FAIL upper.frame din=%h got=%b exp=%b", d, got, frame);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 126; k++) begin
      tick(k < 3, 32'h31 + k);
      checks++;
      if ({txd, busy, fifo_full, overflow} !== exp_v) begin
        errors++;
        $display("FAIL b2b.cycle cyc=%0d got=%b exp=%b", cyc, {txd, busy, fifo_full, overflow}, exp_v);
      end
      if (k == 41 || k == 81) begin
        checks++;
        if ({txd, busy} !== 2'b01) begin
          errors++;
          $display("FAIL b2b.start_bit k=%0d got=%b exp=01", k, {txd, busy});
        end
      end
      if (k == 120 || k == 121) begin
        checks++;
        if ({txd, busy} !== {1'b1, (k == 120)}) begin
          errors++;
          $display("FAIL b2b.end k=%0d got=%b exp=%b", k, {txd, busy}, {1'b1, (k == 120)});
        end
      end
    end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 204; k++) begin
      tick(k < 6, 32'h01 + k);
      checks++;
      if ({txd, busy, fifo_full, overflow} !== exp_v) begin
        errors++;
        $display("FAIL ovf.cycle cyc=%0d got=%b exp=%b", cyc, {txd, busy, fifo_full, overflow}, exp_v);
      end
      if (k == 4 || k == 5) begin
        checks++;
        if ({fifo_full, overflow} !== {1'b1, (k == 5)}) begin
          errors++;
          $display("FAIL ovf.flag k=%0d got=%b exp=%b", k, {fifo_full, overflow}, {1'b1, (k == 5)});
        end
      end
      if (k == 200 || k == 201) begin
        checks++;
        if ({busy, overflow} !== {(k == 200), 1'b1}) begin
          errors++;
          $display("FAIL ovf.end k=%0d got=%b exp=%b", k, {busy, overflow}, {(k == 200), 1'b1});
        end
      end
    end
    do_reset();
  endtask

  task automatic test_push_pop_full();
    int guard;
    for (int k = 0; k < 6; k++) begin
      tick(k == 0 || k >= 2, (k == 0) ? 32'hA0 : $urandom());
      checks++;
      if ({txd, busy, fifo_full, overflow} !== exp_v) begin
        errors++;
        $display("FAIL pp.fill cyc=%0d got=%b exp=%b", cyc, {txd, busy, fifo_full, overflow}, exp_v);
      end
    end
    guard = 0;
    while (cyc + 1 != m_start + 10*DIV && guard < 60) begin
      tick(1'b0, 32'h0);
      guard++;
      checks++;
      if ({txd, busy, fifo_full, overflow} !== exp_v) begin
        errors++;
        $display("FAIL pp.wait cyc=%0d got=%b exp=%b", cyc, {txd, busy, fifo_full, overflow}, exp_v);
      end
    end
    tick(1'b1, 32'h7E);
    checks++;
    if ({fifo_full, overflow} !== 2'b10) begin
      errors++;
      $display("FAIL pp.same_edge got=%b exp=10", {fifo_full, overflow});
    end
    for (int k = 0; k < 205; k++) begin
      tick(1'b0, 32'h0);
      checks++;
      if ({txd, busy, fifo_full, overflow} !== exp_v) begin
        errors++;
        $display("FAIL pp.drain cyc=%0d got=%b exp=%b", cyc, {txd, busy, fifo_full, overflow}, exp_v);
      end
    end
    checks++;
    if ({txd, busy, overflow} !== 3'b100) begin
      errors++;
      $display("FAIL pp.idle got=%b exp=100", {txd, busy, overflow});
    end
  endtask

  task automatic test_reset_mid_frame();
    int guard;
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, (k == 0) ? 32'hA5 : $urandom());
      checks++;
      if ({txd, busy, fifo_full, overflow} !== exp_v) begin
        errors++;
        $display("FAIL rmid.load cyc=%0d got=%b exp=%b", cyc, {txd, busy, fifo_full, overflow}, exp_v);
      end
    end
    guard = 0;
    while (cyc != m_start + 17 && guard < 40) begin
      tick(1'b0, 32'h0);
      guard++;
      checks++;
      if ({txd, busy, fifo_full, overflow} !== exp_v) begin
        errors++;
        $display("FAIL rmid.run cyc=%0d got=%b exp=%b", cyc, {txd, busy, fifo_full, overflow}, exp_v);
      end
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({txd, busy, fifo_full} !== 3'b100) begin
      errors++;
      $display("FAIL rmid.async got=%b exp=100", {txd, busy, fifo_full});
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick(1'b0, 32'h0);
      checks++;
      if ({txd, busy, fifo_full, overflow} !== exp_v) begin
        errors++;
        $display("FAIL rmid.quiet cyc=%0d got=%b exp=%b", cyc, {txd, busy, fifo_full, overflow}, exp_v);
      end
    end
  endtask

  task automatic test_random();
    logic w;
    for (int k = 0; k < 1200; k++) begin
      w = (k < 900) && (($urandom_range(0, 11) == 0) || (k >= 400 && k < 407));
      tick(w, $urandom());
      checks++;
      if ({txd, busy, fifo_full, overflow} !== exp_v) begin
        errors++;
        $display("FAIL rand.cycle cyc=%0d got=%b exp=%b", cyc, {txd, busy, fifo_full, overflow}, exp_v);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_upper_bits();
    test_back_to_back();
    test_overflow();
    test_push_pop_full();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
